// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, ALU result selects, sequencer states and select encoder
package alu_seq_pkg;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;
  localparam logic [3:0] RSEL_OR  = 4'd0;
  localparam logic [3:0] RSEL_AND = 4'd1;
  localparam logic [3:0] RSEL_XOR = 4'd2;
  localparam logic [3:0] RSEL_ADD = 4'd3;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MUL, S_DONE} state_t;
  // alu_sel = {2'b00, result select, invert B, invert A}; MUL reuses the adder
  function automatic logic [7:0] sel_for(input logic [2:0] op);
    return op == OP_AND ? {2'b00, RSEL_AND, 2'b00} :
           op == OP_OR  ? {2'b00, RSEL_OR,  2'b00} :
           op == OP_XOR ? {2'b00, RSEL_XOR, 2'b00} :
           op == OP_ADD ? {2'b00, RSEL_ADD, 2'b00} :
           op == OP_SUB ? {2'b00, RSEL_ADD, 2'b10} :
           op == OP_NOR ? {2'b00, RSEL_AND, 2'b11} :
           op == OP_MUL ? {2'b00, RSEL_ADD, 2'b00} : 8'd0;
  endfunction
endpackage

// File: rtl/alu_seq_mul_dp.sv
// alu_seq_mul_dp: shift-and-add multiply registers; early exit under ALU_SEQ_MUL_EARLY_EXIT_EN
module alu_seq_mul_dp #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  output logic [WIDTH-1:0] o_acc_next,
  output logic [WIDTH-1:0] o_mcand_next,
  output logic             o_last
);
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0] r_cnt;
  assign o_acc_next   = r_mplier[0] ? i_sum : r_acc;
  assign o_mcand_next = r_mcand << 1;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
  // once no multiplier bits remain above bit 0, this step is the final one
  assign o_last = (r_cnt == CNT_W'(WIDTH - 1)) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign o_last = r_cnt == CNT_W'(WIDTH - 1);
`endif
  // load operands on accept, then one conditional add plus shifts per step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= o_acc_next;
      r_mcand  <= o_mcand_next;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for the 64-bit ALU; ALU_SEQ_MUL_EARLY_EXIT_EN enables MUL early exit
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [7:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_err
);
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_t           r_state, w_state;
  logic [2:0]       r_op, w_op;
  logic [WIDTH-1:0] r_alu_a, w_alu_a, r_alu_b, w_alu_b, r_out_result, w_out_result;
  logic [7:0]       r_alu_sel, w_alu_sel;
  logic             r_alu_cin, w_alu_cin, r_out_valid, w_out_valid, r_out_cout, w_out_cout;
  logic             r_out_err, w_out_err, w_load, w_step, w_last;
  logic [WIDTH-1:0] w_acc_next, w_mcand_next;
  assign in_ready   = r_state == S_IDLE;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign alu_cin    = r_alu_cin;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_cout   = r_out_cout;
  assign out_err    = r_out_err;
  alu_seq_mul_dp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_a          (in_a),
    .i_b          (in_b),
    .i_sum        (alu_result),
    .o_acc_next   (w_acc_next),
    .o_mcand_next (w_mcand_next),
    .o_last       (w_last)
  );
  // register state, ALU drive lines and the result bundle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_AND;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_alu_cin    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_cout   <= 1'b0;
      r_out_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_op         <= w_op;
      r_alu_a      <= w_alu_a;
      r_alu_b      <= w_alu_b;
      r_alu_sel    <= w_alu_sel;
      r_alu_cin    <= w_alu_cin;
      r_out_valid  <= w_out_valid;
      r_out_result <= w_out_result;
      r_out_cout   <= w_out_cout;
      r_out_err    <= w_out_err;
    end
  // next state, next ALU drive and result capture
  always_comb begin
    w_state      = r_state;
    w_op         = r_op;
    w_alu_a      = r_alu_a;
    w_alu_b      = r_alu_b;
    w_alu_sel    = r_alu_sel;
    w_alu_cin    = r_alu_cin;
    w_out_valid  = r_out_valid;
    w_out_result = r_out_result;
    w_out_cout   = r_out_cout;
    w_out_err    = r_out_err;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE:
        if (in_valid) begin
          w_op = in_op;
          if (in_op == OP_RSV || (in_op == OP_MUL && EARLY && in_b == '0)) begin
            w_state      = S_DONE;
            w_out_valid  = 1'b1;
            w_out_result = '0;
            w_out_cout   = 1'b0;
            w_out_err    = in_op == OP_RSV;
          end else if (in_op == OP_MUL) begin
            w_state   = S_MUL;
            w_load    = 1'b1;
            w_alu_a   = '0;
            w_alu_b   = in_a;
            w_alu_sel = sel_for(OP_MUL);
            w_alu_cin = 1'b0;
          end else begin
            w_state   = S_ISSUE;
            w_alu_a   = in_a;
            w_alu_b   = in_b;
            w_alu_sel = sel_for(in_op);
            w_alu_cin = in_op == OP_SUB;
          end
        end
      S_ISSUE: begin
        w_state      = S_DONE;
        w_out_valid  = 1'b1;
        w_out_result = alu_result;
        w_out_cout   = (r_op == OP_ADD || r_op == OP_SUB) && alu_cout;
        w_out_err    = 1'b0;
      end
      S_MUL: begin
        w_step  = 1'b1;
        w_alu_a = w_acc_next;
        w_alu_b = w_mcand_next;
        if (w_last) begin
          w_state      = S_DONE;
          w_out_valid  = 1'b1;
          w_out_result = w_acc_next;
          w_out_cout   = 1'b0;
          w_out_err    = 1'b0;
        end
      end
      default:
        if (out_ready) begin
          w_state     = S_IDLE;
          w_out_valid = 1'b0;
        end
    endcase
  end
endmodule
